// File: rtl/dev_timer_pkg.sv
//==============================================================================
// dev_timer_pkg - register map, CTRL bit indices and bus FSM encoding. rev 1.0
//==============================================================================
`default_nettype none

package dev_timer_pkg;

  // Word offsets, decoded from byte address bits [4:2]
  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_PRESC  = 3'd1;
  localparam logic [2:0] TMR_COUNT  = 3'd2;
  localparam logic [2:0] TMR_CMP    = 3'd3;
  localparam logic [2:0] TMR_STATUS = 3'd4;
  localparam logic [2:0] TMR_PWM    = 3'd5;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dev_bus_slave.sv
//==============================================================================
// dev_bus_slave - IDLE/ACK strobe handshake for one device slot. rev 1.0
//==============================================================================
`default_nettype none

module dev_bus_slave
  import dev_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stb,
  input  logic        i_rw,
  input  logic [31:0] i_rdata,
  output logic        o_we,
  output logic        o_re,
  output logic        o_ack,
  output logic [31:0] o_dtr
);

  logic [0:0]  r_state;
  logic [0:0]  w_next;
  logic [31:0] r_dtr;
  logic        w_accept;

  // The master holds addr/dtw stable until ack, so the write lands on the accept edge.
  assign w_accept = (r_state == S_IDLE) && i_stb;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset)         r_dtr <= '0;
    else if (w_accept) r_dtr <= i_rdata;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_stb) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_we  = w_accept & i_rw;
    o_re  = w_accept & ~i_rw;
    o_ack = (r_state == S_ACK);
    o_dtr = o_ack ? r_dtr : 32'd0;
  end

endmodule

`default_nettype wire

// File: rtl/dev_timer.sv
//==============================================================================
// dev_timer - prescaled compare timer with auto-reload and level irq. rev 1.0
// Optional PWM output and PWMCTRL register when DEV_TIMER_PWM_EN is defined.
//==============================================================================
`default_nettype none

module dev_timer
  import dev_timer_pkg::*;
#(
  parameter int MASK_LEN = 8,
  parameter int CNT_W    = 32,
  parameter int PRE_W    = 16
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_stb,
  output logic                o_ack,
  input  logic [MASK_LEN-1:0] i_addr,
  input  logic                i_rw,
  input  logic [31:0]         i_dtw,
  output logic [31:0]         o_dtr,
  output logic                o_irq
`ifdef DEV_TIMER_PWM_EN
  ,
  output logic                o_pwm
`endif
);

  logic [2:0]       r_ctrl;
  logic [PRE_W-1:0] r_presc;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_cmp;
  logic             r_match;
  logic             r_irq;

  logic        w_we, w_re;
  logic [2:0]  w_sel;
  logic [31:0] w_rmux, w_rdata;
  logic        w_wr_ctrl, w_wr_presc, w_wr_count, w_wr_cmp, w_wr_status;
  logic        w_tick, w_hit;
  logic        w_unused;

  dev_bus_slave u_bus (
    .clk     (clk),
    .reset   (reset),
    .i_stb   (i_stb),
    .i_rw    (i_rw),
    .i_rdata (w_rdata),
    .o_we    (w_we),
    .o_re    (w_re),
    .o_ack   (o_ack),
    .o_dtr   (o_dtr)
  );

  assign w_sel       = i_addr[4:2];
  assign w_wr_ctrl   = w_we && (w_sel == TMR_CTRL);
  assign w_wr_presc  = w_we && (w_sel == TMR_PRESC);
  assign w_wr_count  = w_we && (w_sel == TMR_COUNT);
  assign w_wr_cmp    = w_we && (w_sel == TMR_CMP);
  assign w_wr_status = w_we && (w_sel == TMR_STATUS);
  assign w_tick      = r_ctrl[CTRL_EN] && (r_pre_cnt == r_presc);
  assign w_hit       = (r_count == r_cmp);
  assign w_unused    = ^{i_addr, i_dtw};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_presc   <= '0;
      r_pre_cnt <= '0;
      r_count   <= '0;
      r_cmp     <= '0;
      r_match   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_ctrl)  r_ctrl  <= i_dtw[2:0];
      if (w_wr_presc) r_presc <= i_dtw[PRE_W-1:0];
      if (w_wr_cmp)   r_cmp   <= i_dtw[CNT_W-1:0];

      if (w_wr_ctrl || w_wr_presc || !r_ctrl[CTRL_EN] || w_tick) r_pre_cnt <= '0;
      else                                                      r_pre_cnt <= r_pre_cnt + 1'b1;

      // A bus write to COUNT takes priority over the tick update.
      if (w_wr_count)  r_count <= i_dtw[CNT_W-1:0];
      else if (w_tick) r_count <= (w_hit && r_ctrl[CTRL_AUTORELOAD]) ? '0 : r_count + 1'b1;

      if (w_tick && w_hit)             r_match <= 1'b1;
      else if (w_wr_status && i_dtw[0]) r_match <= 1'b0;

      r_irq <= r_match & r_ctrl[CTRL_IRQEN];
    end
  end

`ifdef DEV_TIMER_PWM_EN
  logic r_pwm_inv, r_pwm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_inv <= 1'b0;
      r_pwm     <= 1'b0;
    end else begin
      if (w_we && (w_sel == TMR_PWM)) r_pwm_inv <= i_dtw[0];
      r_pwm <= (r_ctrl[CTRL_EN] && (r_count < r_cmp)) ^ r_pwm_inv;
    end
  end

  assign o_pwm = r_pwm;
`endif

  always_comb begin
    w_rmux = '0;
    case (w_sel)
      TMR_CTRL:   w_rmux[2:0]       = r_ctrl;
      TMR_PRESC:  w_rmux[PRE_W-1:0] = r_presc;
      TMR_COUNT:  w_rmux[CNT_W-1:0] = r_count;
      TMR_CMP:    w_rmux[CNT_W-1:0] = r_cmp;
      TMR_STATUS: w_rmux[0]         = r_match;
`ifdef DEV_TIMER_PWM_EN
      TMR_PWM:    w_rmux[0]         = r_pwm_inv;
`endif
      default:    w_rmux            = '0;
    endcase
  end

  assign w_rdata = w_re ? w_rmux : 32'd0;
  assign o_irq   = r_irq;

endmodule

`default_nettype wire

// File: doc/dev_timer.md
Name: dev_timer

Overview:
- Memory-mapped timer/compare peripheral that sits on one device slot of the device-side bus of the address interconnect.
- Answers the bus with a registered one-cycle strobe/ack handshake.
- Provides a prescaled up-counter with compare match, auto-reload and a level interrupt.
- Produces o_dtr/o_ack for the interconnect's data selector; reads i_dtw/i_rw shared with all devices.

Parameters:
- MASK_LEN, 8, width of the device-local address (o_addr of the interconnect).
- CNT_W, 32, counter and compare width (1..32; narrower registers read zero-extended).
- PRE_W, 16, prescaler width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- i_stb  input  1  device strobe from interconnect (held by master until o_ack)
- o_ack  output  1  transfer done, one-cycle pulse
- i_addr  input  MASK_LEN  device-local byte address
- i_rw  input  1  1=write, 0=read
- i_dtw  input  32  write data
- o_dtr  output  32  read data, valid while o_ack=1
- o_irq  output  1  interrupt, level

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: o_ack=0, o_dtr=0, o_irq=0. CTRL, PRESC, COUNT, CMP, STATUS and the prescaler counter are all 0.
- Register map, decoded on i_addr[4:2]; i_addr[1:0] are ignored:
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
  - 0x04 PRESC: PRE_W bits.
  - 0x08 COUNT: CNT_W bits.
  - 0x0C CMP: CNT_W bits.
  - 0x10 STATUS: bit0 MATCH; write 1 to clear.
  - Other offsets: read 0, write ignored, still acked.
- Handshake FSM, states IDLE and ACK:
  - IDLE and i_stb=1: latch the access, perform a write on this edge, and capture read data. Next state ACK.
  - ACK: o_ack=1 for exactly one cycle with o_dtr holding the captured data. Next state IDLE unconditionally.
  - i_stb during ACK is ignored, so back-to-back accesses take 2 cycles each.
  - o_dtr returns to 0 in IDLE.
  - reset in ACK: go to IDLE; no ack is issued.
- Read data is the register value as of the IDLE/stb edge, before any same-cycle tick.
- Tick generation:
  - When EN=1, the prescaler counts 0..PRESC; at PRESC it returns to 0 and issues tick. PRESC=0 gives a tick every cycle.
  - When EN=0, the prescaler is held at 0 and no ticks occur.
- On tick:
  - If COUNT==CMP: MATCH<=1. COUNT<=0 if AUTORELOAD=1, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Wrap at 2^CNT_W-1 -> 0 without a flag.
- Simultaneous events:
  - A bus write to COUNT overrides the tick update in the same cycle.
  - A write to PRESC or CTRL clears the prescaler counter.
  - A MATCH set and a W1C in the same cycle: set wins.
- o_irq is registered MATCH & IRQEN (one cycle behind MATCH).

Optional Feature:
- Macro DEV_TIMER_PWM_EN.
- When defined: add output o_pwm (1 bit), reset 0, registered value of (EN && COUNT < CMP). Register 0x14 PWMCTRL bit0 INV inverts o_pwm.
- When undefined: no o_pwm port; offset 0x14 reads 0.

Decomposition:
- Shared package holds:
  - register offset constants TMR_CTRL, TMR_PRESC, TMR_COUNT, TMR_CMP, TMR_STATUS, TMR_PWM;
  - CTRL bit-index constants;
  - FSM state encoding (IDLE, ACK).
- One sub-module, dev_bus_slave, holds the IDLE/ACK handshake and the latch of addr/rw/dtw, producing a write-enable and read-strobe. It is reusable by future devices.
- The timer core stays in dev_timer.

Test Plan:
- Reset, then read 0x08 -> o_ack exactly 1 cycle after stb, o_dtr=0, o_irq=0.
- Write CMP=3, PRESC=0, CTRL=0x7 -> COUNT 1,2,3 then 0. STATUS=1 on the edge after COUNT==3 tick; o_irq high one cycle later. Write STATUS=1 -> o_irq drops.
- PRESC=2, CTRL=0x1 -> COUNT increments once every 3 cycles. Write CTRL=0 -> COUNT frozen; read matches.
- CMP=0xFFFFFFFF, COUNT written 0xFFFFFFFE, AUTORELOAD=0 -> MATCH set at 0xFFFFFFFF, then COUNT wraps to 0 and keeps counting.
- Write COUNT=5 on the same edge as a tick -> next read 5. W1C STATUS on a match edge -> MATCH stays 1.
- stb held through ACK; reset asserted while in ACK -> no o_ack pulse, all outputs 0 next cycle.
